// File: rtl/cmd_frame_pkg.sv
// Shared constants for the command framer: frame codes, command-type encodings,
// byte-serializer state encoding and the number of bytes in each frame type.
package cmd_frame_pkg;

    localparam logic [7:0] CODE_RF_WR   = 8'hAA;
    localparam logic [7:0] CODE_RF_RD   = 8'hBB;
    localparam logic [7:0] CODE_ALU_OP  = 8'hCC;
    localparam logic [7:0] CODE_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_NEXT   = 3'd5
    } ser_state_e;

    localparam logic [2:0] NBYTES_RF_WR   = 3'd3;
    localparam logic [2:0] NBYTES_RF_RD   = 3'd2;
    localparam logic [2:0] NBYTES_ALU_OP  = 3'd4;
    localparam logic [2:0] NBYTES_ALU_NOP = 3'd2;

    function automatic logic [2:0] byte_count(input cmd_type_e t);
        logic [2:0] n;
        case (t)
            CMD_RF_WR:  n = NBYTES_RF_WR;
            CMD_RF_RD:  n = NBYTES_RF_RD;
            CMD_ALU_OP: n = NBYTES_ALU_OP;
            default:    n = NBYTES_ALU_NOP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/frame_byte_ser.sv
// Single-byte UART serializer: start bit, data LSB first, optional parity, stop.
// Build option CMD_FRAME_TWO_STOP_EN stretches the stop bit to two bit periods.
//
// state     | meaning
// ST_IDLE   | line high, waiting for i_load
// ST_START  | start bit (0)
// ST_DATA   | data bit r_bit of r_byte
// ST_PARITY | parity bit over r_byte
// ST_STOP   | stop bit(s) (1); exit reloads the next byte or returns to idle
// ST_NEXT   | byte-select decision, folded into the STOP exit, never occupied
module frame_byte_ser #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             i_load,
    input  logic [width-1:0] i_byte,
    input  logic             i_more,
    input  logic [width-1:0] i_next_byte,
    input  logic             i_par_en,
    input  logic             i_par_odd,
    input  logic [4:0]       i_prescale,
    output logic             o_tx,
    output logic             o_byte_end
);
    import cmd_frame_pkg::*;

    localparam int BIT_W = $clog2(width);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(width - 1);

    ser_state_e       r_state;
    logic [4:0]       r_cnt;
    logic [BIT_W-1:0] r_bit;
    logic [width-1:0] r_byte;
    logic             r_tx;
    logic [4:0]       w_pmax;
    logic             w_tick;
    logic             w_stop_last;
    logic [BIT_W-1:0] w_bit_nxt;
    logic             w_parity;

    assign w_pmax    = (i_prescale == 5'd0) ? 5'd0 : i_prescale - 5'd1;
    assign w_tick    = (r_cnt == w_pmax);
    assign w_bit_nxt = r_bit + BIT_W'(1);
    assign w_parity  = i_par_odd ? ~^r_byte : ^r_byte;

`ifdef CMD_FRAME_TWO_STOP_EN
    // Marks the second half of a two-period stop; cleared whenever STOP is left.
    logic r_stop2;
    always_ff @(posedge CLK) begin
        if (Reset || r_state != ST_STOP)
            r_stop2 <= 1'b0;
        else if (w_tick)
            r_stop2 <= 1'b1;
    end
    assign w_stop_last = r_stop2;
`else
    assign w_stop_last = 1'b1;
`endif

    assign o_byte_end = (r_state == ST_STOP) && w_tick && w_stop_last;
    assign o_tx       = r_tx;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_cnt <= (r_state == ST_IDLE || w_tick) ? 5'd0 : r_cnt + 5'd1;
            case (r_state)
                ST_IDLE: if (i_load) begin
                    r_state <= ST_START;
                    r_byte  <= i_byte;
                    r_tx    <= 1'b0;
                end
                ST_START: if (w_tick) begin
                    r_state <= ST_DATA;
                    r_bit   <= '0;
                    r_tx    <= r_byte[0];
                end
                ST_DATA: if (w_tick) begin
                    if (r_bit != LAST_BIT) begin
                        r_bit <= w_bit_nxt;
                        r_tx  <= r_byte[w_bit_nxt];
                    end else if (i_par_en) begin
                        r_state <= ST_PARITY;
                        r_tx    <= w_parity;
                    end else begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                ST_PARITY: if (w_tick) begin
                    r_state <= ST_STOP;
                    r_tx    <= 1'b1;
                end
                ST_STOP: if (o_byte_end) begin
                    if (i_more) begin
                        r_state <= ST_START;
                        r_byte  <= i_next_byte;
                        r_tx    <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/cmd_frame_tx.sv
// Host-side command framer: one command per handshake, framed as 0xAA/0xBB/0xCC/0xDD
// byte sequences and sent as back-to-back UART characters. CMD_FRAME_TWO_STOP_EN selects two stop bits.
module cmd_frame_tx #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [$clog2(depth)-1:0] cmd_addr,
    input  logic [width-1:0]         cmd_data_a,
    input  logic [width-1:0]         cmd_data_b,
    input  logic [3:0]               cmd_fun,
    input  logic                     Parity_EN,
    input  logic                     Parity_type,
    input  logic [4:0]               Prescale,
    output logic                     Tx_serial,
    output logic                     Busy,
    output logic                     frame_done
);
    import cmd_frame_pkg::*;

    localparam int AW = $clog2(depth);

    function automatic logic [width-1:0] frame_byte(
        input cmd_type_e        t,
        input logic [1:0]       idx,
        input logic [AW-1:0]    addr,
        input logic [width-1:0] a,
        input logic [width-1:0] b,
        input logic [3:0]       fun
    );
        logic [width-1:0] v;
        v = '0;
        case (t)
            CMD_RF_WR: case (idx)
                2'd0:    v = width'(CODE_RF_WR);
                2'd1:    v = width'(addr);
                2'd2:    v = a;
                default: v = '0;
            endcase
            CMD_RF_RD: case (idx)
                2'd0:    v = width'(CODE_RF_RD);
                2'd1:    v = width'(addr);
                default: v = '0;
            endcase
            CMD_ALU_OP: case (idx)
                2'd0:    v = width'(CODE_ALU_OP);
                2'd1:    v = a;
                2'd2:    v = b;
                default: v = width'(fun);
            endcase
            default: case (idx)
                2'd0:    v = width'(CODE_ALU_NOP);
                2'd1:    v = width'(fun);
                default: v = '0;
            endcase
        endcase
        return v;
    endfunction

    cmd_type_e        r_type;
    logic [AW-1:0]    r_addr;
    logic [width-1:0] r_data_a;
    logic [width-1:0] r_data_b;
    logic [3:0]       r_fun;
    logic             r_par_en;
    logic             r_par_odd;
    logic [4:0]       r_prescale;
    logic [2:0]       r_nbytes;
    logic [1:0]       r_byte_idx;
    logic             r_busy;
    logic             r_ready;
    logic             r_done;
    logic             w_accept;
    logic             w_last_byte;
    logic             w_byte_end;
    logic             w_tx;
    logic [1:0]       w_idx_nxt;
    logic [width-1:0] w_first_byte;
    logic [width-1:0] w_next_byte;

    assign w_accept     = cmd_valid && r_ready;
    assign w_idx_nxt    = r_byte_idx + 2'd1;
    assign w_last_byte  = (({1'b0, r_byte_idx} + 3'd1) == r_nbytes);
    // The first byte is loaded on the accept edge, before the fields are latched.
    assign w_first_byte = frame_byte(cmd_type_e'(cmd_type), 2'd0, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun);
    assign w_next_byte  = frame_byte(r_type, w_idx_nxt, r_addr, r_data_a, r_data_b, r_fun);

    frame_byte_ser #(
        .width(width)
    ) u_ser (
        .CLK         (CLK),
        .Reset       (Reset),
        .i_load      (w_accept),
        .i_byte      (w_first_byte),
        .i_more      (!w_last_byte),
        .i_next_byte (w_next_byte),
        .i_par_en    (r_par_en),
        .i_par_odd   (r_par_odd),
        .i_prescale  (r_prescale),
        .o_tx        (w_tx),
        .o_byte_end  (w_byte_end)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_type     <= CMD_RF_WR;
            r_addr     <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_fun      <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_prescale <= '0;
            r_nbytes   <= NBYTES_RF_RD;
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_type     <= cmd_type_e'(cmd_type);
                r_addr     <= cmd_addr;
                r_data_a   <= cmd_data_a;
                r_data_b   <= cmd_data_b;
                r_fun      <= cmd_fun;
                r_par_en   <= Parity_EN;
                r_par_odd  <= Parity_type;
                r_prescale <= Prescale;
                r_nbytes   <= byte_count(cmd_type_e'(cmd_type));
                r_byte_idx <= '0;
                r_busy     <= 1'b1;
                r_ready    <= 1'b0;
            end else if (r_busy && w_byte_end) begin
                if (w_last_byte) begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                end else begin
                    r_byte_idx <= w_idx_nxt;
                end
            end
        end
    end

    assign cmd_ready  = r_ready;
    assign Busy       = r_busy;
    assign frame_done = r_done;
    assign Tx_serial  = w_tx;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Bench for cmd_frame_tx: directed and random commands compared cycle by cycle
// against a line waveform built from the command's byte list.
`timescale 1ns/1ps
module tb_cmd_frame_tx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = '0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_data_a = '0;
    logic [7:0] cmd_data_b = '0;
    logic [3:0] cmd_fun = '0;
    logic       Parity_EN = 1'b0;
    logic       Parity_type = 1'b0;
    logic [4:0] Prescale = '0;
    logic       Tx_serial;
    logic       Busy;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int exp_bits[$];
    int stop_bits;

    always #5 CLK = ~CLK;

    cmd_frame_tx #(.width(WIDTH), .depth(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data_a(cmd_data_a),
        .cmd_data_b(cmd_data_b), .cmd_fun(cmd_fun), .Parity_EN(Parity_EN),
        .Parity_type(Parity_type), .Prescale(Prescale), .Tx_serial(Tx_serial),
        .Busy(Busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: byte list per command type, then UART bits per byte.
    task automatic build_frame(input int t, input int addr, input int a, input int b,
                               input int fun, input int pe, input int pt);
        int bytes[$];
        exp_bits.delete();
        case (t)
            0:       bytes = '{'hAA, addr, a};
            1:       bytes = '{'hBB, addr};
            2:       bytes = '{'hCC, a, b, fun};
            default: bytes = '{'hDD, fun};
        endcase
        foreach (bytes[i]) begin
            int d;
            int ones;
            d = bytes[i] & 255;
            ones = 0;
            exp_bits.push_back(0);
            for (int k = 0; k < 8; k++) begin
                exp_bits.push_back((d >> k) & 1);
                ones += (d >> k) & 1;
            end
            if (pe != 0) exp_bits.push_back(pt != 0 ? ((ones % 2) == 0 ? 1 : 0) : ones % 2);
            for (int s = 0; s < stop_bits; s++) exp_bits.push_back(1);
        end
    endtask

    task automatic drive_fields(input int t, input int addr, input int a, input int b,
                                input int fun, input int pe, input int pt, input int ps);
        cmd_type    = 2'(t);
        cmd_addr    = 4'(addr);
        cmd_data_a  = 8'(a);
        cmd_data_b  = 8'(b);
        cmd_fun     = 4'(fun);
        Parity_EN   = 1'(pe);
        Parity_type = 1'(pt);
        Prescale    = 5'(ps);
    endtask

    task automatic scramble();
        drive_fields($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 31));
    endtask

    // Entered and left at a negedge. hold keeps cmd_valid high with the same fields.
    task automatic run_cmd(input string tag, input int t, input int addr, input int a,
                           input int b, input int fun, input int pe, input int pt,
                           input int ps, input int hold, input int bp, input int abort_at,
                           input int expect_nowait);
        int p, L, waited, mism_tx, mism_busy, mism_rdy, n_done, done_at, quiet, exp_tx;
        p = (ps == 0) ? 1 : ps;
        build_frame(t, addr, a, b, fun, pe, pt);
        L = exp_bits.size() * p;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        chk({tag, "_ready"}, cmd_ready, 1);
        if (expect_nowait != 0) chk({tag, "_b2b_wait"}, waited, 0);
        drive_fields(t, addr, a, b, fun, pe, pt, ps);
        cmd_valid = 1'b1;
        @(negedge CLK);
        if (hold == 0) begin
            cmd_valid = 1'b0;
            scramble();
        end
        mism_tx = 0; mism_busy = 0; mism_rdy = 0; n_done = 0; done_at = -1;
        for (int c = 1; c <= L + 1; c++) begin
            exp_tx = (c <= L) ? exp_bits[(c - 1) / p] : 1;
            if (Tx_serial !== 1'(exp_tx)) mism_tx++;
            if (Busy !== (c <= L)) mism_busy++;
            if (cmd_ready !== (c > L)) mism_rdy++;
            if (frame_done === 1'b1) begin
                n_done++;
                done_at = c;
            end
            if (bp != 0 && c == L / 2) begin
                scramble();
                cmd_valid = 1'b1;
            end else if (bp != 0 && c == L / 2 + 1) begin
                cmd_valid = 1'b0;
            end
            if (c == abort_at) begin
                Reset = 1'b1;
                @(negedge CLK);
                chk({tag, "_rst_outputs"}, {Tx_serial, Busy, cmd_ready, frame_done}, 4'b1010);
                Reset = 1'b0;
                quiet = 0;
                for (int w = 0; w < L; w++) begin
                    @(negedge CLK);
                    if (frame_done !== 1'b0 || Tx_serial !== 1'b1 || Busy !== 1'b0) quiet++;
                end
                chk({tag, "_post_rst_quiet"}, quiet, 0);
                chk({tag, "_pre_rst_tx"}, mism_tx, 0);
                return;
            end
            if (c <= L) @(negedge CLK);
        end
        chk({tag, "_tx_mism"}, mism_tx, 0);
        chk({tag, "_busy_mism"}, mism_busy, 0);
        chk({tag, "_ready_mism"}, mism_rdy, 0);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_done_at"}, done_at, L + 1);
        if (hold == 0) begin
            @(negedge CLK);
            chk({tag, "_idle_after"}, {Tx_serial, Busy, frame_done, cmd_ready}, 4'b1001);
        end
    endtask

    initial begin
        int pe_r, bpb;
`ifdef CMD_FRAME_TWO_STOP_EN
        stop_bits = 2;
`else
        stop_bits = 1;
`endif
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_tx", Tx_serial, 1);
        chk("reset_busy", Busy, 0);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_done", frame_done, 0);
        Reset = 1'b0;
        @(negedge CLK);

        run_cmd("rfwr_p8", 0, 3, 'h20, 0, 0, 0, 0, 8, 0, 0, -1, 0);
        run_cmd("rfrd_even", 1, 5, 0, 0, 0, 1, 0, 4, 0, 0, -1, 0);
        run_cmd("rfrd_odd", 1, 5, 0, 0, 0, 1, 1, 4, 0, 0, -1, 0);
        run_cmd("alu_p0", 2, 0, 'h0A, 'h05, 1, 0, 0, 0, 0, 0, -1, 0);

        run_cmd("b2b_first", 3, 0, 0, 0, 2, 0, 0, 2, 1, 0, -1, 0);
        run_cmd("b2b_second", 3, 0, 0, 0, 2, 0, 0, 2, 0, 0, -1, 1);

        run_cmd("backpress", 2, 0, 'h3C, 'hC3, 9, 1, 1, 3, 0, 1, -1, 0);

        bpb = 9 + stop_bits;
        run_cmd("abort", 0, 7, 'h5A, 0, 0, 0, 0, 4, 0, 0, bpb * 4 + 4 * 4 + 1, 0);
        run_cmd("after_abort", 0, 9, 'hE1, 0, 0, 0, 0, 4, 0, 0, -1, 0);

        for (int r = 0; r < 25; r++) begin
            pe_r = $urandom_range(0, 1);
            run_cmd("rand", $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 15), pe_r, $urandom_range(0, 1),
                    $urandom_range(0, 6), 0, $urandom_range(0, 1), -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
